// File: rtl/wme_seq_pack.sv
// Shared types, opcodes and instruction builder for the channel-estimate sequencer.
package wme_seq_pack;

    // Fallback geometry; the integrating design overrides these parameters.
    localparam int unsigned DEF_NTI   = 16;
    localparam int unsigned DEF_DEPTH = 30;
    localparam int unsigned DEF_PREC  = 10;

    localparam logic WME_OP_READ  = 1'b0;
    localparam logic WME_OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StLwait,
        StSetup,
        StExec,
        StGap,
        StRwait,
        StOut,
        StDone
    } wme_seq_state_e;

    // Packs {op, ti, tap} into the low bits; caller truncates to its instruction width.
    function automatic logic [31:0] wme_build_inst(input logic op, input int unsigned ti,
                                                   input int unsigned tap,
                                                   input int unsigned w_ti,
                                                   input int unsigned w_tap);
        logic [31:0] inst;
        inst = 32'(tap) | (32'(ti) << w_tap) | (32'(op) << (w_ti + w_tap));
        return inst;
    endfunction

endpackage

// File: rtl/wme_chan_addr_counter.sv
// Two-level wrapping (TI inner, tap outer) entry counter for the table walk.
module wme_chan_addr_counter #(
    parameter int unsigned NTI   = 16,
    parameter int unsigned DEPTH = 30,
    parameter int unsigned W_TI  = $clog2(NTI),
    parameter int unsigned W_TAP = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             clear,
    input  logic             advance,
    output logic [W_TI-1:0]  ti_idx,
    output logic [W_TAP-1:0] tap_idx,
    output logic             last
);

    localparam logic [W_TI-1:0]  TI_LAST  = W_TI'(NTI - 1);
    localparam logic [W_TAP-1:0] TAP_LAST = W_TAP'(DEPTH - 1);

    // Last entry of the table is the final TI slice of the final tap.
    assign last = (ti_idx == TI_LAST) && (tap_idx == TAP_LAST);

    // TI index wraps into a tap increment; the whole counter wraps after the last entry.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ti_idx  <= '0;
            tap_idx <= '0;
        end else if (clear) begin
            ti_idx  <= '0;
            tap_idx <= '0;
        end else if (advance) begin
            if (ti_idx == TI_LAST) begin
                ti_idx  <= '0;
                tap_idx <= (tap_idx == TAP_LAST) ? '0 : tap_idx + 1'b1;
            end else begin
                ti_idx <= ti_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wme_chan_sequencer.sv
// Full-table load/dump sequencer driving the weight manager channel-estimate debug port.
module wme_chan_sequencer
    import wme_seq_pack::*;
#(
    parameter int unsigned NTI      = DEF_NTI,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned PREC     = DEF_PREC,
    parameter int unsigned EXEC_GAP = 2,
    parameter int unsigned READ_LAT = 2,
    localparam int unsigned W_TI    = $clog2(NTI),
    localparam int unsigned W_TAP   = $clog2(DEPTH),
    localparam int unsigned W_INST  = W_TI + W_TAP + 1
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   start_load,
    input  logic                   start_dump,
    input  logic                   abort,
    input  logic signed [PREC-1:0] load_data,
    input  logic                   load_valid,
    output logic                   load_ready,
    output logic signed [PREC-1:0] dump_data,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            wme_chan_data,
    output logic [W_INST-1:0]      wme_chan_inst,
    output logic                   wme_chan_exec,
    input  logic signed [PREC-1:0] wme_chan_read
);

    wme_seq_state_e   state_q;
    logic             op_q;
    logic [7:0]       cnt_q;
    logic [W_TI-1:0]  ti_idx;
    logic [W_TAP-1:0] tap_idx;
    logic             last;
    logic             cnt_clear;
    logic             cnt_advance;

    wme_chan_addr_counter #(
        .NTI   (NTI),
        .DEPTH (DEPTH),
        .W_TI  (W_TI),
        .W_TAP (W_TAP)
    ) u_addr (
        .clk     (clk),
        .rstb    (rstb),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .ti_idx  (ti_idx),
        .tap_idx (tap_idx),
        .last    (last)
    );

    // Instruction follows the registered opcode and counters, so it settles on entry to
    // LWAIT/SETUP and stays put through EXEC and GAP.
    assign wme_chan_inst = W_INST'(wme_build_inst(op_q, 32'(ti_idx), 32'(tap_idx), W_TI, W_TAP));

    // Counter control: abort clears, the final GAP cycle steps to the next entry.
    always_comb begin
        cnt_clear   = abort;
        cnt_advance = (state_q == StGap) && (cnt_q == '0) && !abort;
    end

    // Sequencer FSM; every handshake and port strobe is a registered output.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q       <= StIdle;
            op_q          <= WME_OP_READ;
            cnt_q         <= '0;
            load_ready    <= 1'b0;
            dump_valid    <= 1'b0;
            dump_data     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            wme_chan_exec <= 1'b0;
            wme_chan_data <= '0;
        end else if (abort) begin
            // Pending handshakes are discarded; an already-fired exec is not revisited.
            state_q       <= StIdle;
            load_ready    <= 1'b0;
            dump_valid    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            wme_chan_exec <= 1'b0;
        end else begin
            wme_chan_exec <= 1'b0;
            done          <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_load) begin
                        op_q       <= WME_OP_WRITE;
                        busy       <= 1'b1;
                        load_ready <= 1'b1;
                        state_q    <= StLwait;
                    end else if (start_dump) begin
                        op_q          <= WME_OP_READ;
                        busy          <= 1'b1;
                        wme_chan_data <= '0;
                        state_q       <= StSetup;
                    end
                end
                StLwait: begin
                    if (load_valid) begin
                        wme_chan_data <= 32'(load_data);
                        load_ready    <= 1'b0;
                        wme_chan_exec <= 1'b1;
                        state_q       <= StExec;
                    end
                end
                StSetup: begin
                    wme_chan_exec <= 1'b1;
                    state_q       <= StExec;
                end
                StExec: begin
                    if (op_q == WME_OP_WRITE) begin
                        cnt_q   <= 8'(EXEC_GAP - 1);
                        state_q <= StGap;
                    end else if (READ_LAT <= 1) begin
                        dump_data  <= wme_chan_read;
                        dump_valid <= 1'b1;
                        state_q    <= StOut;
                    end else begin
                        cnt_q   <= 8'(READ_LAT - 2);
                        state_q <= StRwait;
                    end
                end
                StRwait: begin
                    if (cnt_q == '0) begin
                        dump_data  <= wme_chan_read;
                        dump_valid <= 1'b1;
                        state_q    <= StOut;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StOut: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        cnt_q      <= 8'(EXEC_GAP - 1);
                        state_q    <= StGap;
                    end
                end
                StGap: begin
                    if (cnt_q == '0) begin
                        if (last) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StDone;
                        end else if (op_q == WME_OP_WRITE) begin
                            load_ready <= 1'b1;
                            state_q    <= StLwait;
                        end else begin
                            state_q <= StSetup;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wme_chan_sequencer.sv
// Directed bench for wme_chan_sequencer: reset, load, dump, start arbitration and abort.
module tb_wme_chan_sequencer;

    localparam int unsigned NTI      = 16;
    localparam int unsigned DEPTH    = 30;
    localparam int unsigned PREC     = 10;
    localparam int unsigned EXEC_GAP = 2;
    localparam int unsigned READ_LAT = 2;
    localparam int unsigned W_INST   = 10;
    localparam int          N_ENT    = 480;

    logic                   clk = 1'b0;
    logic                   rstb = 1'b0;
    logic                   start_load = 1'b0;
    logic                   start_dump = 1'b0;
    logic                   abort = 1'b0;
    logic signed [PREC-1:0] load_data = '0;
    logic                   load_valid = 1'b0;
    logic                   load_ready;
    logic signed [PREC-1:0] dump_data;
    logic                   dump_valid;
    logic                   dump_ready = 1'b0;
    logic                   busy;
    logic                   done;
    logic [31:0]            wme_chan_data;
    logic [W_INST-1:0]      wme_chan_inst;
    logic                   wme_chan_exec;
    logic signed [PREC-1:0] wme_chan_read = '0;

    int checks = 0;
    int errors = 0;

    wme_chan_sequencer #(
        .NTI      (NTI),
        .DEPTH    (DEPTH),
        .PREC     (PREC),
        .EXEC_GAP (EXEC_GAP),
        .READ_LAT (READ_LAT)
    ) dut (
        .clk           (clk),
        .rstb          (rstb),
        .start_load    (start_load),
        .start_dump    (start_dump),
        .abort         (abort),
        .load_data     (load_data),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .dump_data     (dump_data),
        .dump_valid    (dump_valid),
        .dump_ready    (dump_ready),
        .busy          (busy),
        .done          (done),
        .wme_chan_data (wme_chan_data),
        .wme_chan_inst (wme_chan_inst),
        .wme_chan_exec (wme_chan_exec),
        .wme_chan_read (wme_chan_read)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Debug-port read model: data is valid only in the cycle after exec, so a late or
    // early capture sees the filler pattern.
    function automatic logic [PREC-1:0] rd_val(input logic [W_INST-1:0] inst);
        int unsigned ti;
        int unsigned tap;
        ti  = 32'(inst[8:5]);
        tap = 32'(inst[4:0]);
        return PREC'(ti * 100 + tap);
    endfunction

    function automatic logic [PREC-1:0] exp_dump(input int n);
        return PREC'((n % 16) * 100 + n / 16);
    endfunction

    always @(posedge clk) wme_chan_read <= wme_chan_exec ? rd_val(wme_chan_inst) : 10'h2AA;

    // Port monitor: logs every exec with its inst/data and cycle, and counts done pulses.
    int unsigned       cyc = 0;
    logic [W_INST-1:0] ex_inst[$];
    logic [31:0]       ex_data[$];
    int unsigned       ex_cyc[$];
    int                done_cnt = 0;
    int                unstable_cnt = 0;
    logic [W_INST-1:0] prev_inst = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstb) begin
            if (wme_chan_exec) begin
                ex_inst.push_back(wme_chan_inst);
                ex_data.push_back(wme_chan_data);
                ex_cyc.push_back(cyc);
                if (wme_chan_inst !== prev_inst) unstable_cnt++;
            end
            if (done) done_cnt++;
        end
        prev_inst = wme_chan_inst;
    end

    task automatic clear_mon();
        ex_inst.delete();
        ex_data.delete();
        ex_cyc.delete();
        done_cnt     = 0;
        unstable_cnt = 0;
    endtask

    // Streams entry index k as load data; optional simultaneous start_dump, a start_dump
    // pulse mid-run, and an abort once abort_after execs have been seen.
    task automatic run_load(input bit both, input int abort_after, input bit neg_first);
        int k;
        int seen;
        k = 0;
        seen = 0;
        load_valid = 1'b1;
        load_data  = neg_first ? -10'sd5 : 10'sd0;
        @(negedge clk);
        start_load = 1'b1;
        start_dump = both;
        @(negedge clk);
        start_load = 1'b0;
        start_dump = 1'b0;
        check("busy_rise", busy, 1);
        for (int c = 0; c < 4000; c++) begin
            if (!busy) break;
            start_dump = (both && c == 10);
            if (wme_chan_exec) seen++;
            if (abort_after > 0 && seen >= abort_after && load_ready) begin
                abort = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
                check("abort_busy_low", busy, 0);
                check("abort_ready_low", load_ready, 0);
                break;
            end
            if (load_ready) begin
                @(posedge clk);
                #1;
                k++;
                load_data = PREC'(k);
            end
            @(negedge clk);
        end
        start_dump = 1'b0;
        load_valid = 1'b0;
    endtask

    typedef struct {
        int          entry;
        logic [9:0]  exp_inst;
        logic [31:0] exp_data;
    } vec_t;

    vec_t              vecs[8];
    logic [PREC-1:0]   dvals[N_ENT];

    initial begin
        int n;
        int bad;
        int bad_val;
        int bad_hold;
        bit pending;
        logic [PREC-1:0] held;

        vecs[0] = '{0,   10'h200, 32'd0};
        vecs[1] = '{1,   10'h220, 32'd1};
        vecs[2] = '{2,   10'h240, 32'd2};
        vecs[3] = '{15,  10'h3E0, 32'd15};
        vecs[4] = '{16,  10'h201, 32'd16};
        vecs[5] = '{17,  10'h221, 32'd17};
        vecs[6] = '{240, 10'h20F, 32'd240};
        vecs[7] = '{479, 10'h3FD, 32'd479};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_load_ready", load_ready, 0);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_exec", wme_chan_exec, 0);
        check("rst_inst", wme_chan_inst, 0);
        check("rst_data", wme_chan_data, 0);
        check("rst_dump_data", dump_data, 0);
        rstb = 1'b1;
        @(negedge clk);

        // Asynchronous reset while exec is high
        clear_mon();
        load_valid = 1'b1;
        load_data  = 10'sd7;
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (wme_chan_exec) break;
            @(negedge clk);
        end
        check("midrst_exec_seen", wme_chan_exec, 1);
        rstb = 1'b0;
        #1;
        check("midrst_exec", wme_chan_exec, 0);
        check("midrst_busy", busy, 0);
        check("midrst_inst", wme_chan_inst, 0);
        check("midrst_data", wme_chan_data, 0);
        @(negedge clk);
        rstb = 1'b1;
        load_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_idle_busy", busy, 0);
        check("midrst_idle_ready", load_ready, 0);
        check("midrst_no_done", done_cnt, 0);

        // Full table load, value = entry index
        clear_mon();
        run_load(1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("load_exec_count", ex_inst.size(), N_ENT);
        check("load_done_count", done_cnt, 1);
        check("load_busy_end", busy, 0);
        check("load_inst_stable", unstable_cnt, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("load_inst_e%0d", vecs[i].entry), ex_inst[vecs[i].entry],
                  vecs[i].exp_inst);
            check($sformatf("load_data_e%0d", vecs[i].entry), ex_data[vecs[i].entry],
                  vecs[i].exp_data);
        end
        bad = 0;
        for (int i = 0; i < ex_inst.size(); i++) begin
            if (ex_inst[i] !== {1'b1, 4'(i % 16), 5'(i / 16)} || ex_data[i] !== 32'(i)) bad++;
        end
        check("load_sweep_mismatches", bad, 0);
        if (ex_cyc.size() >= 2) check("load_entry_period", ex_cyc[1] - ex_cyc[0], 4);
        else check("load_entry_period", ex_cyc.size(), 2);

        // Simultaneous starts: load wins; a later start_dump while busy is ignored
        clear_mon();
        run_load(1'b1, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("both_exec_count", ex_inst.size(), N_ENT);
        check("both_first_inst", ex_inst[0], 10'h200);
        bad = 0;
        foreach (ex_inst[i]) if (!ex_inst[i][W_INST-1]) bad++;
        check("both_read_execs", bad, 0);
        check("both_done_count", done_cnt, 1);

        // Abort after 37 writes, first value negative
        clear_mon();
        run_load(1'b0, 37, 1'b1);
        repeat (10) @(negedge clk);
        check("abort_exec_count", ex_inst.size(), 37);
        check("abort_no_done", done_cnt, 0);
        check("abort_sext_data", ex_data[0], 32'hFFFF_FFFB);
        check("abort_last_inst", ex_inst[36], 10'h282);
        check("abort_idle_busy", busy, 0);

        // Full dump with dump_ready pattern 1-0-0-1
        clear_mon();
        n = 0;
        bad_val = 0;
        bad_hold = 0;
        pending = 1'b0;
        held = '0;
        start_dump = 1'b1;
        @(negedge clk);
        start_dump = 1'b0;
        for (int c = 0; c < 8000 && n < N_ENT; c++) begin
            dump_ready = (c % 4 == 0) || (c % 4 == 3);
            if (dump_valid) begin
                if (!pending) begin
                    pending = 1'b1;
                    held = dump_data;
                    dvals[n] = dump_data;
                    if (dump_data !== exp_dump(n)) bad_val++;
                end else if (dump_data !== held) begin
                    bad_hold++;
                end
                if (dump_ready) begin
                    n++;
                    pending = 1'b0;
                end
            end else if (pending) begin
                bad_hold++;
            end
            @(negedge clk);
        end
        dump_ready = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (!busy) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("dump_count", n, N_ENT);
        check("dump_value_mismatches", bad_val, 0);
        check("dump_hold_violations", bad_hold, 0);
        check("dump_val_0", dvals[0], 10'd0);
        check("dump_val_1", dvals[1], 10'd100);
        check("dump_val_16", dvals[16], 10'd1);
        check("dump_val_479", dvals[479], 10'h1F9);
        check("dump_exec_count", ex_inst.size(), N_ENT);
        check("dump_restart_inst0", ex_inst[0], 10'h000);
        check("dump_inst1", ex_inst[1], 10'h020);
        bad = 0;
        foreach (ex_inst[i]) if (ex_inst[i][W_INST-1] || ex_data[i] !== 32'd0) bad++;
        check("dump_write_or_data", bad, 0);
        check("dump_inst_stable", unstable_cnt, 0);
        check("dump_done_count", done_cnt, 1);
        check("dump_busy_end", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
